// File: rtl/uart_rx_os.sv
// ============================================================================
// Module   : uart_rx_os
// Function : Oversampling UART receiver with 3-sample majority voting,
//            configurable frame format, error flags and an FWFT receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_os #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rxd,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_BITS-1:0]           m_data,
    output logic                           m_frame_err,
    output logic                           m_parity_err,
    output logic                           m_break,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow,
    input  logic                           clr_overflow,
    output logic                           rx_busy
);

    localparam int OS_DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int SC_W   = $clog2(OVERSAMPLE);
    localparam int H      = OVERSAMPLE / 2;
    localparam int BI_W   = $clog2(DATA_BITS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = DATA_BITS + 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_sync;
    logic                   w_rxs;
    logic [DIV_W-1:0]       r_div;
    logic [SC_W-1:0]        r_sc;
    logic                   r_s1;
    logic                   r_s2;
    logic [BI_W-1:0]        r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bit;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_stop1;
    logic                   r_stop_idx;

    logic                   w_tick;
    logic                   w_mid;
    logic                   w_end;
    logic                   w_maj;
    logic                   w_push;
    logic                   w_last_stop;
    logic                   w_ferr_fin;
    logic                   w_stop1_fin;
    logic                   w_brk;
    logic [WORD_W-1:0]      w_word;

    logic [WORD_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;
    logic                   w_valid;
    logic                   w_pop;
    logic                   w_push_ok;
    logic [WORD_W-1:0]      w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rxd};
        end
    end
    assign w_rxs = r_sync[1];

    assign w_tick = (r_state != S_IDLE) && (r_div == DIV_W'(OS_DIV - 1));
    assign w_mid  = w_tick && (r_sc == SC_W'(H + 1));
    assign w_end  = w_tick && (r_sc == SC_W'(OVERSAMPLE - 1));
    assign w_maj  = (r_s1 & r_s2) | (r_s1 & w_rxs) | (r_s2 & w_rxs);

    assign w_last_stop = (r_stop_idx == 1'(STOP_BITS - 1));
    assign w_ferr_fin  = (r_stop_idx == 1'b0) ? ~w_maj : (r_ferr | ~w_maj);
    assign w_stop1_fin = (r_stop_idx == 1'b0) ? w_maj : r_stop1;
    assign w_brk       = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && !w_stop1_fin;
    assign w_word      = {w_brk, r_perr, w_ferr_fin, r_shift};

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_mid && w_maj) begin
                    w_state_nxt = S_IDLE;
                end else if (w_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_end && (r_bit == BI_W'(DATA_BITS - 1))) begin
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at mid-bit so a back-to-back start edge is not missed.
                if (w_mid && w_last_stop) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_sc       <= '0;
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop1    <= 1'b1;
            r_stop_idx <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_div      <= '0;
            r_sc       <= '0;
            r_bit      <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop_idx <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_sc <= (r_sc == SC_W'(OVERSAMPLE - 1)) ? '0 : r_sc + 1'b1;
                if (r_sc == SC_W'(H - 1)) begin
                    r_s1 <= w_rxs;
                end
                if (r_sc == SC_W'(H)) begin
                    r_s2 <= w_rxs;
                end
            end
            if (r_state == S_DATA) begin
                if (w_mid) begin
                    r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                end
                if (w_end) begin
                    r_bit <= r_bit + 1'b1;
                end
            end
            if ((r_state == S_PARITY) && w_mid) begin
                r_par_bit <= w_maj;
                r_perr    <= (PARITY == 1) ? ~(^r_shift ^ w_maj) : (^r_shift ^ w_maj);
            end
            if (r_state == S_STOP) begin
                if (w_mid && (r_stop_idx == 1'b0)) begin
                    r_ferr  <= ~w_maj;
                    r_stop1 <= w_maj;
                end
                if (w_end) begin
                    r_stop_idx <= 1'b1;
                end
            end
        end
    end

    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && m_ready;
    assign w_push_ok = w_push && ((r_count != CNT_W'(FIFO_DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Mask the head so outputs read zero whenever the FIFO is empty.
    assign w_head       = w_valid ? r_mem[r_rptr] : '0;
    assign m_valid      = w_valid;
    assign m_data       = w_head[DATA_BITS-1:0];
    assign m_frame_err  = w_head[DATA_BITS];
    assign m_parity_err = w_head[DATA_BITS+1];
    assign m_break      = w_head[DATA_BITS+2];
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;
    assign rx_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os.sv
// ============================================================================
// Module   : tb_uart_rx_os
// Function : Scoreboard bench for uart_rx_os (8N1 and 8E1 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic       m_ready_a = 1'b0;
    logic       m_ready_b = 1'b0;
    logic       clr_a = 1'b0;
    logic       clr_b = 1'b0;

    logic       m_valid_a, m_valid_b;
    logic [7:0] m_data_a, m_data_b;
    logic       ferr_a, ferr_b, perr_a, perr_b, brk_a, brk_b;
    logic [4:0] cnt_a, cnt_b;
    logic       ovf_a, ovf_b, busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;

    logic [10:0] q_a[$];
    logic [10:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
        .m_frame_err(ferr_a), .m_parity_err(perr_a), .m_break(brk_a),
        .fifo_count(cnt_a), .overflow(ovf_a), .clr_overflow(clr_a),
        .rx_busy(busy_a)
    );

    uart_rx_os #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
        .m_frame_err(ferr_b), .m_parity_err(perr_b), .m_break(brk_b),
        .fifo_count(cnt_b), .overflow(ovf_b), .clr_overflow(clr_b),
        .rx_busy(busy_b)
    );

    function automatic logic [10:0] mk(input logic brk, input logic perr,
                                       input logic ferr, input logic [7:0] d);
        return {brk, perr, ferr, d};
    endfunction

    // Scoreboard monitors: compare the head word on every accepted pop.
    always @(negedge clk) begin
        if (rst_n && m_valid_a && m_ready_a) begin
            logic [10:0] act_a;
            act_a = {brk_a, perr_a, ferr_a, m_data_a};
            n_vec++;
            if (q_a.size() == 0) begin
                n_err++;
                $display("FAIL pop_a: unexpected word actual=%03h required=none", act_a);
            end else begin
                logic [10:0] exp_a;
                exp_a = q_a.pop_front();
                if (act_a !== exp_a) begin
                    n_err++;
                    $display("FAIL pop_a: actual={brk,perr,ferr,data}=%03h required=%03h", act_a, exp_a);
                end
            end
        end
        if (rst_n && m_valid_b && m_ready_b) begin
            logic [10:0] act_b;
            act_b = {brk_b, perr_b, ferr_b, m_data_b};
            n_vec++;
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL pop_b: unexpected word actual=%03h required=none", act_b);
            end else begin
                logic [10:0] exp_b;
                exp_b = q_b.pop_front();
                if (act_b !== exp_b) begin
                    n_err++;
                    $display("FAIL pop_b: actual={brk,perr,ferr,data}=%03h required=%03h", act_b, exp_b);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
    endtask

    task automatic send_bit(input bit sel, input logic v);
        drive(sel, v);
        tick(16);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (has_par) send_bit(sel, par);
        send_bit(sel, stop);
        send_bit(sel, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (i < 2000 && (q_a.size() != 0 || q_b.size() != 0)) begin
            tick(1);
            i++;
        end
        n_vec++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: actual pending=%0d required=0", q_a.size() + q_b.size());
        end
        tick(2);
    endtask

    initial begin
        tick(3);
        chk("rst_valid", m_valid_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_overflow", ovf_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_head", {brk_a, perr_a, ferr_a, m_data_a}, 0);
        rst_n = 1'b1;
        tick(4);

        m_ready_a = 1'b1;
        m_ready_b = 1'b1;

        q_a.push_back(mk(0, 0, 0, 8'h55));
        send_frame(0, 8'h55, 0, 0, 1);
        wait_drain();
        chk("ovf_after_55", ovf_a, 0);

        // 0xA3 has four ones: even parity bit is 0.
        q_b.push_back(mk(0, 0, 0, 8'hA3));
        send_frame(1, 8'hA3, 1, 1'b0, 1);
        q_b.push_back(mk(0, 1, 0, 8'hA3));
        send_frame(1, 8'hA3, 1, 1'b1, 1);
        wait_drain();

        q_a.push_back(mk(1, 0, 1, 8'h00));
        send_frame(0, 8'h00, 0, 0, 0);
        tick(16 * 12);
        q_a.push_back(mk(0, 0, 0, 8'h7E));
        send_frame(0, 8'h7E, 0, 0, 1);
        wait_drain();

        drive(0, 1'b0);
        tick(3);
        drive(0, 1'b1);
        tick(2);
        chk("glitch_busy_hi", busy_a, 1);
        tick(40);
        chk("glitch_busy_lo", busy_a, 0);
        chk("glitch_no_push", cnt_a, 0);

        // 0xFF frame with only the centre sample of data bit 0 flipped low.
        q_a.push_back(mk(0, 0, 0, 8'hFF));
        send_bit(0, 1'b0);
        drive(0, 1'b1); tick(9);
        drive(0, 1'b0); tick(1);
        drive(0, 1'b1); tick(6);
        for (int i = 1; i < 8; i++) send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        wait_drain();

        m_ready_a = 1'b0;
        for (int i = 0; i <= 16; i++) send_frame(0, 8'(i), 0, 0, 1);
        tick(10);
        chk("full_count", cnt_a, 16);
        chk("full_overflow", ovf_a, 1);
        for (int i = 0; i < 16; i++) q_a.push_back(mk(0, 0, 0, 8'(i)));
        m_ready_a = 1'b1;
        wait_drain();
        chk("drained_count", cnt_a, 0);
        chk("ovf_sticky", ovf_a, 1);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        tick(1);
        chk("ovf_cleared", ovf_a, 0);

        m_ready_a = 1'b0;
        send_frame(0, 8'h99, 0, 0, 1);
        chk("pre_rst_count", cnt_a, 1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        drive(0, 1'b1); tick(8);
        rst_n = 1'b0;
        tick(3);
        chk("midrst_valid", m_valid_a, 0);
        chk("midrst_count", cnt_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_head", {brk_a, perr_a, ferr_a, m_data_a}, 0);
        chk("midrst_overflow", ovf_a, 0);
        rst_n = 1'b1;
        tick(4);
        m_ready_a = 1'b1;
        q_a.push_back(mk(0, 0, 0, 8'h3C));
        send_frame(0, 8'h3C, 0, 0, 1);
        wait_drain();
        chk("final_count", cnt_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
